// File: rtl/mlt_datapath.sv
// Shift-and-add multiplier datapath: A operand register, B down-counter,
// P accumulator with sticky overflow, and a done-edge result capture with
// a valid/ready handshake on the captured value.
module mlt_datapath #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [W-1:0]   data_in,
  input  logic           lda,
  input  logic           ldb,
  input  logic           ldp,
  input  logic           clr_p,
  input  logic           dec_b,
  input  logic           done,
  input  logic           result_ready,
  output logic           eqz,
  output logic [2*W-1:0] product,
  output logic [2*W-1:0] result,
  output logic           result_valid,
  output logic           ovf
);

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] p_q;
  logic           done_q;
  logic [2*W:0]   sum;
  logic           capture;

  // One extra bit on the sum exposes the carry out of the accumulator.
  assign sum     = {1'b0, p_q} + {{(W+1){1'b0}}, a_q};
  assign capture = done && !done_q;
  assign eqz     = (b_q == '0);
  assign product = p_q;

  // A operand register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      a_q <= '0;
    else if (lda)
      a_q <= data_in;
  end

  // B counter: load wins over decrement, decrement saturates at zero
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      b_q <= '0;
    else if (ldb)
      b_q <= data_in;
    else if (dec_b && (b_q != '0))
      b_q <= b_q - W'(1);
  end

  // P accumulator and sticky overflow: clear wins over accumulate
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      p_q <= '0;
      ovf <= 1'b0;
    end else if (clr_p) begin
      p_q <= '0;
      ovf <= 1'b0;
    end else if (ldp) begin
      p_q <= sum[2*W-1:0];
      if (sum[2*W])
        ovf <= 1'b1;
    end
  end

  // Result capture on done rising edge; a capture outranks a consume
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      done_q       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      done_q <= done;
      if (capture) begin
        result       <= p_q;
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mlt_datapath.sv
// Directed bench for mlt_datapath: a W=16 instance for the functional
// sequences and a W=8 instance (sharing the controls) for overflow, so the
// accumulator can be walked to the top of its range in a few hundred cycles.
module tb_mlt_datapath;

  logic        clk;
  logic        resetn;
  logic [15:0] data_in;
  logic        lda, ldb, ldp, clr_p, dec_b, done, result_ready;

  logic        eqz16, rv16, ovf16;
  logic [31:0] product16, result16;
  logic        eqz8, rv8, ovf8;
  logic [15:0] product8, result8;

  int unsigned n_tests;
  int unsigned n_fail;

  mlt_datapath #(.W(16)) u_dut16 (
    .clk          (clk),
    .resetn       (resetn),
    .data_in      (data_in),
    .lda          (lda),
    .ldb          (ldb),
    .ldp          (ldp),
    .clr_p        (clr_p),
    .dec_b        (dec_b),
    .done         (done),
    .result_ready (result_ready),
    .eqz          (eqz16),
    .product      (product16),
    .result       (result16),
    .result_valid (rv16),
    .ovf          (ovf16)
  );

  mlt_datapath #(.W(8)) u_dut8 (
    .clk          (clk),
    .resetn       (resetn),
    .data_in      (data_in[7:0]),
    .lda          (lda),
    .ldb          (ldb),
    .ldp          (ldp),
    .clr_p        (clr_p),
    .dec_b        (dec_b),
    .done         (done),
    .result_ready (result_ready),
    .eqz          (eqz8),
    .product      (product8),
    .result       (result8),
    .result_valid (rv8),
    .ovf          (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lda = 0; ldb = 0; ldp = 0; clr_p = 0; dec_b = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    data_in = '0;
    idle_inputs();
    done = 0; result_ready = 0;
    resetn = 1;
    step(); step();
    resetn = 0;
    step();

    // reset state
    check("rst_eqz", eqz16, 1);
    check("rst_product", product16, 0);
    check("rst_result", result16, 0);
    check("rst_valid", rv16, 0);
    check("rst_ovf", ovf16, 0);
    ldp = 1; step(); ldp = 0;
    check("rst_a_zero", product16, 0);

    // 7 x 3
    clr_p = 1; step(); clr_p = 0;
    lda = 1; data_in = 16'd7; step(); lda = 0;
    ldb = 1; data_in = 16'd3; step(); ldb = 0;
    check("mul_eqz_loaded", eqz16, 0);
    for (int i = 0; i < 3; i++) begin
      ldp = 1; step(); ldp = 0;
      dec_b = 1; step(); dec_b = 0;
      check("mul_eqz_iter", eqz16, (i == 2) ? 1 : 0);
    end
    check("mul_product", product16, 21);
    done = 1; step(); done = 0;
    check("mul_result", result16, 21);
    check("mul_valid", rv16, 1);
    result_ready = 1; step(); result_ready = 0;
    check("mul_consumed", rv16, 0);

    // decrement at zero saturates
    for (int i = 0; i < 4; i++) begin
      dec_b = 1; step(); dec_b = 0;
      check("uf_eqz", eqz16, 1);
    end
    check("uf_product", product16, 21);
    ldp = 1; step(); ldp = 0;
    check("uf_a_kept", product16, 28);

    // done held 6 cycles: one capture, result stable while P moves
    done = 1; step();
    check("hs_first_result", result16, 28);
    check("hs_first_valid", rv16, 1);
    ldp = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hs_hold_result", result16, 28);
      check("hs_hold_valid", rv16, 1);
    end
    ldp = 0; done = 0;
    check("hs_p_moved", product16, 63);
    result_ready = 1; step(); result_ready = 0;
    check("hs_consumed", rv16, 0);

    // capture while valid and not ready overwrites
    done = 1; step(); done = 0;
    check("ow_first", result16, 63);
    ldp = 1; step(); ldp = 0;
    done = 1; step(); done = 0;
    check("ow_result", result16, 70);
    check("ow_valid", rv16, 1);

    // capture and ready at the same edge: capture wins
    ldp = 1; step(); ldp = 0;
    done = 1; result_ready = 1; step(); done = 0;
    check("sim_valid", rv16, 1);
    check("sim_result", result16, 77);
    step(); result_ready = 0;
    check("sim_consumed", rv16, 0);

    // ldb beats dec_b
    ldb = 1; dec_b = 1; data_in = 16'd5; step(); ldb = 0; dec_b = 0;
    for (int i = 0; i < 5; i++) begin
      dec_b = 1; step(); dec_b = 0;
      check("ldb_count_eqz", eqz16, (i == 4) ? 1 : 0);
    end

    // clr_p beats ldp
    clr_p = 1; ldp = 1; step(); idle_inputs();
    check("clr_product16", product16, 0);
    check("clr_ovf16", ovf16, 0);

    // overflow on W=8: walk P to 0xFFF0
    lda = 1; data_in = 16'h00FF; step(); lda = 0;
    ldp = 1;
    for (int i = 0; i < 256; i++) step();
    ldp = 0;
    check("ov_p_ff00", product8, 16'hFF00);
    lda = 1; data_in = 16'h00F0; step(); lda = 0;
    ldp = 1; step(); ldp = 0;
    check("ov_p_fff0", product8, 16'hFFF0);
    lda = 1; data_in = 16'h000F; step(); lda = 0;
    ldp = 1; step(); ldp = 0;
    check("ov_p_ffff", product8, 16'hFFFF);
    check("ov_none_at_max", ovf8, 0);
    lda = 1; data_in = 16'h0020; step(); lda = 0;
    ldp = 1; step(); ldp = 0;
    check("ov_wrap", product8, 16'h001F);
    check("ov_set", ovf8, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("ov_sticky", ovf8, 1);
    end
    clr_p = 1; ldp = 1; step(); idle_inputs();
    check("ov_clr_p", product8, 0);
    check("ov_clr_flag", ovf8, 0);

    // lda with ldp uses the old A (A8 = 0x20)
    lda = 1; ldp = 1; data_in = 16'h0001; step(); idle_inputs();
    check("old_a", product8, 16'h0020);
    ldp = 1; step(); ldp = 0;
    check("new_a", product8, 16'h0021);

    // asynchronous reset between edges
    done = 1; step(); done = 0;
    check("pre_rst_valid", rv8, 1);
    #3 resetn = 1;
    #1;
    check("ar_eqz", eqz16, 1);
    check("ar_product", product8, 0);
    check("ar_result", result8, 0);
    check("ar_valid", rv8, 0);
    check("ar_ovf", ovf16, 0);
    step();
    resetn = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_capture", rv16, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mlt_datapath.md
MLT_DATAPATH -- requirements
Module: mlt_datapath

Interface
REQ-001 Parameter: W, default 16, operand width in bits; product and result are 2W bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset; asynchronous, active-high (despite the name).
REQ-004 data_in  input  W  operand bus shared by A and B loads.
REQ-005 lda  input  1  load A register from data_in.
REQ-006 ldb  input  1  load B counter from data_in.
REQ-007 ldp  input  1  accumulate: P <= P + zero-extended A.
REQ-008 clr_p  input  1  clear P and ovf.
REQ-009 dec_b  input  1  decrement B counter.
REQ-010 done  input  1  controller completion level; rising edge triggers result capture.
REQ-011 result_ready  input  1  consumer accepts result.
REQ-012 eqz  output  1  high when B == 0; combinational decode of the B register only.
REQ-013 product  output  2W  live P register value.
REQ-014 result  output  2W  captured product.
REQ-015 result_valid  output  1  result holds an unconsumed product.
REQ-016 ovf  output  1  sticky P accumulation overflow flag.

Function
REQ-017 lda high: A <= data_in at the next edge; otherwise A holds.
REQ-018 ldb high: B <= data_in; ldb has priority over a simultaneous dec_b.
REQ-019 dec_b with B != 0: B <= B - 1; dec_b with B == 0: B holds at 0 (no wrap), no other effect.
REQ-020 clr_p high: P <= 0 and ovf <= 0; clr_p has priority over a simultaneous ldp.
REQ-021 ldp high without clr_p: P <= (P + A) mod 2^(2W); if the true sum is >= 2^(2W), ovf <= 1.
REQ-022 ovf clears only on reset or clr_p.
REQ-023 ldb and ldp in the same cycle are independent and both take effect.
REQ-024 lda and ldp in the same cycle: ldp uses the old A.
REQ-025 All load, clear and decrement inputs take effect in one cycle; eqz reflects the new B the cycle after the edge.
REQ-026 Capture: a registered done_q tracks done. When done=1 and done_q=0: result <= P, result_valid <= 1 at that edge.
REQ-027 done held high for several cycles captures exactly once.
REQ-028 result_valid=1 and result_ready=1 at an edge: result_valid <= 0 at that edge unless a capture occurs there. A capture at the same edge wins: result_valid stays 1 with the new P.
REQ-029 Capture while result_valid=1 and result_ready=0: result is overwritten with the new P and result_valid stays 1.
REQ-030 While result_valid=1 and no capture occurs, result stays stable regardless of the other inputs.

Reset
REQ-031 resetn high asynchronously forces A=0, B=0, P=0, done_q=0, result=0, result_valid=0, ovf=0. Consequently eqz=1 and product=0.
REQ-032 Reset mid-operation abandons all state immediately, with no dependence on the clock edge. After release, no capture occurs until a fresh done rising edge.

Verification
REQ-033 Reset: assert resetn between edges -> outputs take the REQ-031 values before the next edge; eqz=1.
REQ-034 W=16 multiply: clr_p, lda with data_in=7, ldb with data_in=3, then 3x(ldp; dec_b) -> product=21, eqz=1 after the third dec_b; done pulse -> result=21, result_valid=1 on the next cycle.
REQ-035 Underflow: B=0, pulse dec_b 4 times -> B stays 0, eqz=1, P/A unchanged.
REQ-036 Overflow: P=0xFFFF_FFF0, A=0x0020, ldp -> product=0x0000_0010, ovf=1; ovf stays 1 for 10 cycles; clr_p together with ldp -> P=0, ovf=0.
REQ-037 Handshake: done held high for 6 cycles with result_ready=0 -> single capture; result stable, result_valid=1 throughout; result_ready=1 -> result_valid=0 after that edge.
REQ-038 Simultaneous events: capture and result_ready=1 at the same edge -> result_valid stays 1 with the new value; ldb=5 together with dec_b -> B=5.
